// File: rtl/dc_miss_ctrl_if.sv
// rtl/dc_miss_ctrl_if.sv - beat-request memory bus between the miss controller and memory
interface dc_miss_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dc_miss_ctrl.sv
// rtl/dc_miss_ctrl.sv - dcache miss/evict and uncached IO sequencer onto a beat bus
module dc_miss_ctrl #(
  parameter int LINE_W = 128,
  parameter int BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_miss,
  input  logic [31:0]       dc_miss_addr,
  input  logic              dc_evict,
  input  logic [31:0]       dc_evict_addr,
  input  logic [LINE_W-1:0] dc_evict_data,
  output logic [LINE_W-1:0] dc_data_fill,
  output logic              dc_miss_ack,
  input  logic              io_access,
  input  logic              io_rw,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_wr_data,
  output logic [31:0]       io_rd_data,
  output logic              io_ack,
  dc_miss_ctrl_if.master    mem,
  output logic              mc_busy
);
  localparam int NB = LINE_W / BUS_W;

  typedef enum logic [3:0] {
    IDLE, EVICT, FILL_REQ, FILL_WAIT, ACK, IO_REQ, IO_WAIT, IO_ACK, COOL
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        beat;
  logic [27:0]       miss_line_a;
  logic [27:0]       evict_line_a;
  logic [LINE_W-1:0] evict_line;
  logic [29:0]       io_word_a;
  logic              io_we;
  logic [31:0]       io_wd;
  logic [BUS_W-1:0]  line_words [NB];
  logic              accept;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{dc_miss_addr[3:0], dc_evict_addr[3:0], io_addr[1:0]};
  assign accept = mem.mem_req & mem.mem_gnt;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      line_words[i] = evict_line[i*BUS_W +: BUS_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (io_access)                state_nxt = IO_REQ;
        else if (dc_miss && dc_evict) state_nxt = EVICT;
        else if (dc_miss)             state_nxt = FILL_REQ;
      end
      EVICT:     if (accept && beat == 2'd3) state_nxt = FILL_REQ;
      FILL_REQ:  if (accept) state_nxt = FILL_WAIT;
      FILL_WAIT: if (mem.mem_rvalid) state_nxt = (beat == 2'd3) ? ACK : FILL_REQ;
      ACK:       state_nxt = COOL;
      IO_REQ:    if (accept) state_nxt = io_we ? IO_ACK : IO_WAIT;
      IO_WAIT:   if (mem.mem_rvalid) state_nxt = IO_ACK;
      IO_ACK:    state_nxt = COOL;
      COOL:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode only from state, beat and latched request fields.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'h0;
    mem.mem_wdata = 32'h0;
    case (state)
      EVICT: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {evict_line_a, beat, 2'b00};
        mem.mem_wdata = line_words[beat];
      end
      FILL_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {miss_line_a, beat, 2'b00};
      end
      IO_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = io_we;
        mem.mem_addr  = {io_word_a, 2'b00};
        mem.mem_wdata = io_wd;
      end
      default: ;
    endcase
  end

  assign dc_miss_ack = (state == ACK);
  assign io_ack      = (state == IO_ACK);
  assign mc_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat         <= 2'd0;
      dc_data_fill <= '0;
      io_rd_data   <= 32'h0;
      miss_line_a  <= 28'h0;
      evict_line_a <= 28'h0;
      evict_line   <= '0;
      io_word_a    <= 30'h0;
      io_we        <= 1'b0;
      io_wd        <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // Capturing every idle cycle leaves the exit-edge values in place.
          beat         <= 2'd0;
          miss_line_a  <= dc_miss_addr[31:4];
          evict_line_a <= dc_evict_addr[31:4];
          evict_line   <= dc_evict_data;
          io_word_a    <= io_addr[31:2];
          io_we        <= io_rw;
          io_wd        <= io_wr_data;
        end
        EVICT: begin
          if (accept) beat <= beat + 2'd1;
        end
        FILL_WAIT: begin
          if (mem.mem_rvalid) begin
            for (int i = 0; i < NB; i++) begin
              if (beat == 2'(i)) dc_data_fill[i*BUS_W +: BUS_W] <= mem.mem_rdata;
            end
            beat <= beat + 2'd1;
          end
        end
        IO_WAIT: begin
          if (mem.mem_rvalid) io_rd_data <= mem.mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dc_miss_ctrl.sv
// tb/tb_dc_miss_ctrl.sv - scoreboard bench for dc_miss_ctrl
module tb_dc_miss_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         dc_miss, dc_evict, io_access, io_rw;
  logic [31:0]  dc_miss_addr, dc_evict_addr, io_addr, io_wr_data;
  logic [127:0] dc_evict_data;
  logic [127:0] dc_data_fill;
  logic         dc_miss_ack, io_ack, mc_busy;
  logic [31:0]  io_rd_data;

  dc_miss_ctrl_if bus();

  dc_miss_ctrl #(.LINE_W(128), .BUS_W(32)) dut (
    .clk(clk), .rst(rst),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_evict(dc_evict), .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
    .dc_data_fill(dc_data_fill), .dc_miss_ack(dc_miss_ack),
    .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr), .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data), .io_ack(io_ack),
    .mem(bus), .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { logic wr; logic [31:0] rd; } io_t;

  beat_t        exp_beat_q[$];
  logic [31:0]  rd_q[$];
  logic [127:0] exp_fill_q[$];
  io_t          exp_io_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_acc_cyc = 0, acc_reads = 0, dc_ack_cnt = 0, io_ack_cnt = 0;
  int rv_cnt = 0, stall_left = 0;
  logic stall_armed = 1'b0;
  logic cool_chk = 1'b0;
  logic [31:0] pend = 32'h0;

  // Memory model and scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    io_t e;
    logic [127:0] f;
    cyc++;
    bus.mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pend;
      end
    end
    if (cool_chk) begin
      checks++;
      if (bus.mem_req !== 1'b0 || mc_busy !== 1'b1) begin
        errors++;
        $display("FAIL cool_cycle: mem_req=%b mc_busy=%b, required 0/1", bus.mem_req, mc_busy);
      end
      cool_chk = 1'b0;
    end
    if (dc_miss_ack === 1'b1) begin
      checks++;
      cool_chk = 1'b1;
      dc_ack_cnt++;
      if (exp_fill_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dc_miss_ack: got ack, required none");
      end else begin
        f = exp_fill_q.pop_front();
        if (dc_data_fill !== f) begin
          errors++;
          $display("FAIL dc_data_fill: got %h required %h", dc_data_fill, f);
        end
      end
    end
    if (io_ack === 1'b1) begin
      checks++;
      cool_chk = 1'b1;
      io_ack_cnt++;
      if (exp_io_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_io_ack: got ack, required none");
      end else begin
        e = exp_io_q.pop_front();
        if (io_rd_data !== e.rd || cyc != last_acc_cyc + (e.wr ? 1 : 3)) begin
          errors++;
          $display("FAIL io_ack: rd=%h lat=%0d, required rd=%h lat=%0d",
                   io_rd_data, cyc - last_acc_cyc, e.rd, e.wr ? 1 : 3);
        end
      end
    end
    if (bus.mem_req === 1'b1 && stall_armed && bus.mem_we === 1'b1 && bus.mem_addr[3:2] == 2'd2) begin
      stall_armed = 1'b0;
      stall_left  = 5;
    end
    if (stall_left > 0) begin
      bus.mem_gnt = 1'b0;
      stall_left--;
      checks++;
      if (exp_beat_q.size() == 0 || bus.mem_req !== 1'b1 ||
          bus.mem_addr !== exp_beat_q[0].addr || bus.mem_wdata !== exp_beat_q[0].wdata) begin
        errors++;
        $display("FAIL stall_hold: req=%b addr=%h wdata=%h, required held beat", bus.mem_req, bus.mem_addr, bus.mem_wdata);
      end
    end else if (bus.mem_req === 1'b1) begin
      bus.mem_gnt = 1'b1;
      last_acc_cyc = cyc;
      checks++;
      if (exp_beat_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: we=%b addr=%h", bus.mem_we, bus.mem_addr);
      end else begin
        b = exp_beat_q.pop_front();
        if (bus.mem_we !== b.we || bus.mem_addr !== b.addr || (b.we && bus.mem_wdata !== b.wdata)) begin
          errors++;
          $display("FAIL beat: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, b.we, b.addr, b.wdata);
        end
      end
      if (bus.mem_we === 1'b0) begin
        rv_cnt = 2;
        pend = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0_0000;
        acc_reads++;
      end
    end else begin
      bus.mem_gnt = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (mc_busy === lvl) break;
      step();
    end
    if (i == 100) begin
      checks++;
      errors++;
      $display("FAIL %s: mc_busy never reached %b", name, lvl);
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      step();
      if (exp_beat_q.size() == 0 && exp_fill_q.size() == 0 && exp_io_q.size() == 0 &&
          rd_q.size() == 0 && mc_busy === 1'b0) break;
    end
    checks++;
    if (i == 400) begin
      errors++;
      $display("FAIL %s_done: beats=%0d fills=%0d ios=%0d left, required 0", name,
               exp_beat_q.size(), exp_fill_q.size(), exp_io_q.size());
    end
  endtask

  task automatic push_fill(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      exp_beat_q.push_back('{1'b0, {base[31:4], 4'h0} + 32'(4 * i), 32'h0});
      rd_q.push_back(w[i]);
    end
    exp_fill_q.push_back({w3, w2, w1, w0});
  endtask

  task automatic push_evict(input logic [31:0] base, input logic [127:0] line);
    for (int i = 0; i < 4; i++) begin
      exp_beat_q.push_back('{1'b1, {base[31:4], 4'h0} + 32'(4 * i), line[i*32 +: 32]});
    end
  endtask

  task automatic drive_miss(input logic [31:0] a, input logic ev, input logic [31:0] ea, input logic [127:0] line);
    dc_miss = 1'b1; dc_miss_addr = a; dc_evict = ev; dc_evict_addr = ea; dc_evict_data = line;
    step();
    wait_busy(1'b1, "miss_start");
    dc_miss = 1'b0; dc_evict = 1'b0;
    dc_miss_addr = 32'hFFFF_FFF0; dc_evict_addr = 32'hEEEE_EEE0; dc_evict_data = {4{32'h5A5A_5A5A}};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if ({bus.mem_req, bus.mem_we, dc_miss_ack, io_ack, mc_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {bus.mem_req, bus.mem_we, dc_miss_ack, io_ack, mc_busy});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (dc_data_fill !== 128'h0 || io_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: fill=%h io_rd=%h required 0", dc_data_fill, io_rd_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_miss();
    push_fill(32'h0000_1230, 32'h11, 32'h22, 32'h33, 32'h44);
    drive_miss(32'h0000_1230, 1'b0, 32'h0, 128'h0);
    wait_done("clean_miss");
    repeat (3) step();
    checks++;
    if (dc_data_fill !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("FAIL fill_hold: got %h required 00000044000000330000002200000011", dc_data_fill);
    end
  endtask

  task automatic test_dirty_miss(input logic stall);
    logic [127:0] line;
    line = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000} ^ {4{stall ? 32'h0F0F_0000 : 32'h0}};
    stall_armed = stall;
    push_evict(32'h0000_0A40, line);
    push_fill(32'h0000_2004, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004 + 32'(stall));
    drive_miss(32'h0000_2004, 1'b1, 32'h0000_0A40, line);
    wait_done(stall ? "stall_miss" : "dirty_miss");
    if (stall) begin
      checks++;
      if (stall_armed !== 1'b0 || stall_left != 0) begin
        errors++;
        $display("FAIL stall_seen: armed=%b left=%0d required 0/0", stall_armed, stall_left);
      end
    end
  endtask

  task automatic test_io_priority();
    int acks0;
    acks0 = io_ack_cnt;
    exp_beat_q.push_back('{1'b0, 32'h0000_F000, 32'h0});
    rd_q.push_back(32'hCAFE_F00D);
    exp_io_q.push_back('{1'b0, 32'hCAFE_F00D});
    push_fill(32'h0000_3000, 32'h0000_0A01, 32'h0000_0A02, 32'h0000_0A03, 32'h0000_0A04);
    io_access = 1'b1; io_rw = 1'b0; io_addr = 32'h0000_F003; io_wr_data = 32'h1234_5678;
    dc_miss = 1'b1; dc_miss_addr = 32'h0000_3000; dc_evict = 1'b0;
    step();
    wait_busy(1'b1, "io_start");
    io_access = 1'b0; io_addr = 32'h0;
    for (int i = 0; i < 100 && io_ack_cnt == acks0; i++) step();
    wait_busy(1'b0, "io_idle");
    wait_busy(1'b1, "miss_after_io");
    dc_miss = 1'b0;
    wait_done("io_priority");
  endtask

  task automatic test_io_write();
    exp_beat_q.push_back('{1'b1, 32'h0000_1008, 32'hDEAD_BEEF});
    exp_io_q.push_back('{1'b1, 32'hCAFE_F00D});
    io_access = 1'b1; io_rw = 1'b1; io_addr = 32'h0000_1008; io_wr_data = 32'hDEAD_BEEF;
    step();
    wait_busy(1'b1, "io_write_start");
    io_access = 1'b0; io_wr_data = 32'h0;
    wait_done("io_write");
  endtask

  task automatic test_reset_mid();
    int reads0, acks0;
    reads0 = acc_reads;
    acks0 = dc_ack_cnt;
    push_fill(32'h0000_4000, 32'h77, 32'h88, 32'h99, 32'hAA);
    void'(exp_fill_q.pop_back());
    drive_miss(32'h0000_4000, 1'b0, 32'h0, 128'h0);
    for (int i = 0; i < 100 && acc_reads < reads0 + 2; i++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_beat_q.delete();
    rd_q.delete();
    repeat (5) step();
    checks++;
    if (dc_ack_cnt != acks0 || mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ack: acks=%0d busy=%b required %0d/0", dc_ack_cnt, mc_busy, acks0);
    end
    checks++;
    if (dc_data_fill !== 128'h0 || io_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_data: fill=%h io_rd=%h required 0", dc_data_fill, io_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    push_fill(32'h0000_7FF0, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404);
    drive_miss(32'h0000_7FF8, 1'b0, 32'h0, 128'h0);
    wait_done("after_reset_miss");
    push_evict(32'h0000_8000, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    push_fill(32'h0000_9000, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
    drive_miss(32'h0000_9000, 1'b1, 32'h0000_8000, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    wait_done("back_to_back");
  endtask

  initial begin
    rst = 1'b1;
    dc_miss = 1'b0; dc_evict = 1'b0; io_access = 1'b0; io_rw = 1'b0;
    dc_miss_addr = 32'h0; dc_evict_addr = 32'h0; dc_evict_data = 128'h0;
    io_addr = 32'h0; io_wr_data = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_clean_miss();
    test_dirty_miss(1'b0);
    test_dirty_miss(1'b1);
    test_io_priority();
    test_io_write();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dc_miss_ctrl.md
DC_MISS_CTRL -- requirements
Module: dc_miss_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-002 SHALL have parameter BUS_W, default 32, memory bus width; beats per line NB = LINE_W/BUS_W = 4.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports dc_miss in 1, dc_miss_addr in 32, dc_evict in 1, dc_evict_addr in 32, dc_evict_data in LINE_W: the line-miss request from dcache.
REQ-006 SHALL have ports dc_data_fill out LINE_W and dc_miss_ack out 1: the fill line, and a one-cycle completion strobe.
REQ-007 SHALL have ports io_access in 1, io_rw in 1 (1 = write), io_addr in 32, io_wr_data in 32: the uncached request.
REQ-008 SHALL have ports io_rd_data out 32 and io_ack out 1: the uncached read data and completion strobe.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_gnt in 1: the beat-request bus; a beat is accepted in a cycle with mem_req & mem_gnt.
REQ-010 SHALL have ports mem_rvalid in 1 and mem_rdata in 32: read-beat return, one per accepted read beat, arriving at least 1 cycle after acceptance.
REQ-011 SHALL have port mc_busy out 1, high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, EVICT, FILL_REQ, FILL_WAIT, ACK, IO_REQ, IO_WAIT, IO_ACK, COOL.
REQ-013 IDLE: io_access SHALL take priority and go to IO_REQ; otherwise dc_miss & dc_evict SHALL go to EVICT, and dc_miss & !dc_evict SHALL go to FILL_REQ.
REQ-014 SHALL latch miss address[31:4], evict address[31:4], evict line, io_addr[31:2], io_rw and io_wr_data on the IDLE-exit edge; later input changes SHALL be ignored until return to IDLE.
REQ-015 SHALL use a 2-bit beat counter, cleared on entry to EVICT and to FILL_REQ and incremented per accepted beat (EVICT) or per mem_rvalid (FILL_WAIT).
REQ-016 EVICT: mem_req=1, mem_we=1, mem_addr = {evict_addr[31:4], beat, 2'b00}, mem_wdata = line[32*beat+31 : 32*beat]; after the acceptance of beat 3 SHALL go to FILL_REQ.
REQ-017 FILL_REQ: mem_req=1, mem_we=0, mem_addr = {miss_addr[31:4], beat, 2'b00}; on acceptance SHALL go to FILL_WAIT.
REQ-018 FILL_WAIT: mem_req=0; on mem_rvalid SHALL write mem_rdata to fill bits [32*beat+31 : 32*beat]; if beat = 3 SHALL go to ACK, else to FILL_REQ. One read beat SHALL be outstanding at most.
REQ-019 ACK: dc_miss_ack=1 for exactly one cycle with the complete dc_data_fill; dc_data_fill SHALL hold its value until the next fill beat is written; then SHALL go to COOL.
REQ-020 IO_REQ: mem_req=1, mem_we=io_rw, mem_addr={io_addr[31:2],2'b00}, mem_wdata=io_wr_data; on acceptance a write SHALL go to IO_ACK and a read to IO_WAIT.
REQ-021 IO_WAIT: on mem_rvalid SHALL register mem_rdata into io_rd_data and go to IO_ACK; io_rd_data SHALL hold until the next IO read.
REQ-022 IO_ACK: io_ack=1 for exactly one cycle, then SHALL go to COOL.
REQ-023 COOL: all requests SHALL be ignored for one cycle (the requester updates tag and arbiter state); then SHALL go to IDLE.
REQ-024 mem_req SHALL stay asserted, with addr, we and wdata stable, until mem_gnt; mem_req=0 in IDLE, FILL_WAIT, IO_WAIT, ACK, IO_ACK and COOL.
REQ-025 mem_rvalid outside FILL_WAIT/IO_WAIT SHALL be ignored; mem_gnt without mem_req SHALL be ignored.
REQ-026 Beat counter wrap 3->0 SHALL occur only on the transitions named above; no beat SHALL be repeated or skipped.
REQ-027 All outputs SHALL be registered or decoded from state/counter only; no combinational input-to-output path.

Reset
REQ-028 With rst high at a clock edge: state=IDLE, beat=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dc_miss_ack=0, io_ack=0, dc_data_fill=0, io_rd_data=0, mc_busy=0.
REQ-029 Reset mid-transaction SHALL abandon it without an ack; a later mem_rvalid for the abandoned beat SHALL be ignored (REQ-025).

Verification
REQ-030 Clean miss: dc_miss=1, dc_evict=0, addr 0x0000_1230; gnt immediate, rvalid 2 cycles later, rdata 0x11,0x22,0x33,0x44 -> 4 read beats to 0x1230/34/38/3C; dc_miss_ack single pulse with dc_data_fill = 0x00000044_00000033_00000022_00000011.
REQ-031 Dirty miss: dc_evict=1, evict addr 0x0000_0A40, line {W3,W2,W1,W0} -> 4 writes to 0xA40..0xA4C, W0 first, then 4 fill reads, then one ack.
REQ-032 Stalled bus: mem_gnt low 5 cycles during EVICT beat 2 -> mem_req, mem_addr and mem_wdata held constant; no beat lost or duplicated.
REQ-033 IO priority: io_access=1 (read, 0x0000_F003) and dc_miss=1 together -> IO read to 0xF000 first; io_ack with io_rd_data = mem_rdata; COOL cycle; then miss serviced.
REQ-034 Reset during FILL_WAIT beat 1, then stray rvalid -> IDLE, no ack, dc_data_fill=0, mc_busy=0.
REQ-035 IO write: io_rw=1, data 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; io_ack one cycle after the accepting cycle; no IO_WAIT visit.
